// File: rtl/icebus_frame_receiver.sv
// icebus_frame_receiver: decodes 9-byte motor-command frames from a UART byte
// stream and updates the setpoint / control mode for one motor.
//
// Frame: 0x55 0xAA motor_id cmd P3 P2 P1 P0 crc8(poly 0x07 over motor_id..P0)
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous active-low reset
//   rx_data / rx_valid   received byte and its one-cycle strobe
//   setpoint             last accepted signed setpoint (cmd 0x01)
//   control_mode         last accepted control mode (cmd 0x02, P0)
//   setpoint_update      one-cycle pulse when setpoint is written
//   control_mode_update  one-cycle pulse when control_mode is written
//   frame_count          valid frames addressed to MOTOR_ID (saturating)
//   crc_error_count      frames failing CRC, any motor_id (saturating)
//   timeout_count        frames abandoned on an inter-byte gap (saturating)
module icebus_frame_receiver #(
  parameter logic [7:0]  MOTOR_ID      = 8'h00,
  parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUDRATE      = 115200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic signed [31:0] setpoint,
  output logic [7:0]         control_mode,
  output logic               setpoint_update,
  output logic               control_mode_update,
  output logic [15:0]        frame_count,
  output logic [15:0]        crc_error_count,
  output logic [15:0]        timeout_count
);

  // Two byte times (10 bits each) of silence abandons a partial frame.
  localparam longint unsigned TIMEOUT_L      = (64'(20) * 64'(CLOCK_FREQ_HZ)) / 64'(BAUDRATE);
  localparam int unsigned     TIMEOUT_CYCLES = 32'(TIMEOUT_L);
  localparam int unsigned     GAP_W          = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_HUNT0,
    S_HUNT1,
    S_ID,
    S_CMD,
    S_PAY,
    S_CRC
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         crc_q, crc_d;
  logic [7:0]         id_q, id_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [31:0]        pay_q, pay_d;
  logic [1:0]         pay_cnt_q, pay_cnt_d;
  logic signed [31:0] setpoint_q, setpoint_d;
  logic [7:0]         control_mode_q, control_mode_d;
  logic               setpoint_update_q, setpoint_update_d;
  logic               control_mode_update_q, control_mode_update_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [15:0]        crc_error_count_q, crc_error_count_d;
  logic [15:0]        timeout_count_q, timeout_count_d;
  logic               timeout_fire;
  state_t             cur_state;

  // One byte of MSB-first CRC-8, polynomial x^8+x^2+x+1.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q               <= S_HUNT0;
      gap_q                 <= '0;
      crc_q                 <= '0;
      id_q                  <= '0;
      cmd_q                 <= '0;
      pay_q                 <= '0;
      pay_cnt_q             <= '0;
      setpoint_q            <= '0;
      control_mode_q        <= '0;
      setpoint_update_q     <= 1'b0;
      control_mode_update_q <= 1'b0;
      frame_count_q         <= '0;
      crc_error_count_q     <= '0;
      timeout_count_q       <= '0;
    end else begin
      state_q               <= state_d;
      gap_q                 <= gap_d;
      crc_q                 <= crc_d;
      id_q                  <= id_d;
      cmd_q                 <= cmd_d;
      pay_q                 <= pay_d;
      pay_cnt_q             <= pay_cnt_d;
      setpoint_q            <= setpoint_d;
      control_mode_q        <= control_mode_d;
      setpoint_update_q     <= setpoint_update_d;
      control_mode_update_q <= control_mode_update_d;
      frame_count_q         <= frame_count_d;
      crc_error_count_q     <= crc_error_count_d;
      timeout_count_q       <= timeout_count_d;
    end
  end

  // Next-state, frame assembly and output update.
  always_comb begin
    state_d               = state_q;
    crc_d                 = crc_q;
    id_d                  = id_q;
    cmd_d                 = cmd_q;
    pay_d                 = pay_q;
    pay_cnt_d             = pay_cnt_q;
    setpoint_d            = setpoint_q;
    control_mode_d        = control_mode_q;
    setpoint_update_d     = 1'b0;
    control_mode_update_d = 1'b0;
    frame_count_d         = frame_count_q;
    crc_error_count_d     = crc_error_count_q;
    timeout_count_d       = timeout_count_q;

    // Gap counter saturates so it never wraps back under the threshold.
    if (rx_valid) begin
      gap_d = '0;
    end else if (gap_q >= GAP_W'(TIMEOUT_CYCLES)) begin
      gap_d = gap_q;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end

    // A timeout drops to HUNT0 first; a byte arriving that cycle is hunted on.
    timeout_fire = (state_q != S_HUNT0) && (state_q != S_HUNT1) &&
                   (gap_q >= GAP_W'(TIMEOUT_CYCLES));
    cur_state    = state_q;
    if (timeout_fire) begin
      cur_state       = S_HUNT0;
      state_d         = S_HUNT0;
      timeout_count_d = sat_inc(timeout_count_q);
    end

    if (rx_valid) begin
      unique case (cur_state)
        S_HUNT0: begin
          if (rx_data == 8'h55) state_d = S_HUNT1;
        end
        S_HUNT1: begin
          if (rx_data == 8'hAA)      state_d = S_ID;
          else if (rx_data == 8'h55) state_d = S_HUNT1;
          else                       state_d = S_HUNT0;
        end
        S_ID: begin
          id_d    = rx_data;
          crc_d   = crc8_step(8'h00, rx_data);
          state_d = S_CMD;
        end
        S_CMD: begin
          cmd_d     = rx_data;
          crc_d     = crc8_step(crc_q, rx_data);
          pay_cnt_d = '0;
          state_d   = S_PAY;
        end
        S_PAY: begin
          pay_d     = {pay_q[23:0], rx_data};
          crc_d     = crc8_step(crc_q, rx_data);
          pay_cnt_d = pay_cnt_q + 2'd1;
          if (pay_cnt_q == 2'd3) state_d = S_CRC;
        end
        S_CRC: begin
          state_d = S_HUNT0;
          if (crc_q != rx_data) begin
            crc_error_count_d = sat_inc(crc_error_count_q);
          end else if (id_q == MOTOR_ID) begin
            frame_count_d = sat_inc(frame_count_q);
            if (cmd_q == 8'h01) begin
              setpoint_d        = $signed(pay_q);
              setpoint_update_d = 1'b1;
            end else if (cmd_q == 8'h02) begin
              control_mode_d        = pay_q[7:0];
              control_mode_update_d = 1'b1;
            end
          end
        end
        default: state_d = S_HUNT0;
      endcase
    end
  end

  assign setpoint            = setpoint_q;
  assign control_mode        = control_mode_q;
  assign setpoint_update     = setpoint_update_q;
  assign control_mode_update = control_mode_update_q;
  assign frame_count         = frame_count_q;
  assign crc_error_count     = crc_error_count_q;
  assign timeout_count       = timeout_count_q;

endmodule

// File: tb/tb_icebus_frame_receiver.sv
// Bench for icebus_frame_receiver: frame table, directed corner sequences and
// random traffic, all checked cycle-by-cycle against a frame-level model.
module tb_icebus_frame_receiver;

  localparam int unsigned CLK_HZ = 1_152_000;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned T      = 20 * CLK_HZ / BAUD;  // 200 cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic signed [31:0] setpoint, setpoint4;
  logic [7:0]  control_mode, control_mode4;
  logic        setpoint_update, setpoint_update4;
  logic        control_mode_update, control_mode_update4;
  logic [15:0] frame_count, frame_count4;
  logic [15:0] crc_error_count, crc_error_count4;
  logic [15:0] timeout_count, timeout_count4;

  icebus_frame_receiver #(.MOTOR_ID(8'h03), .CLOCK_FREQ_HZ(CLK_HZ), .BAUDRATE(BAUD)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .setpoint(setpoint), .control_mode(control_mode),
    .setpoint_update(setpoint_update), .control_mode_update(control_mode_update),
    .frame_count(frame_count), .crc_error_count(crc_error_count),
    .timeout_count(timeout_count)
  );

  icebus_frame_receiver #(.MOTOR_ID(8'h04), .CLOCK_FREQ_HZ(CLK_HZ), .BAUDRATE(BAUD)) dut4 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .setpoint(setpoint4), .control_mode(control_mode4),
    .setpoint_update(setpoint_update4), .control_mode_update(control_mode_update4),
    .frame_count(frame_count4), .crc_error_count(crc_error_count4),
    .timeout_count(timeout_count4)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  int     sp_pulses = 0;

  // Frame-level model: position in frame, captured body bytes, expected outputs.
  int          m_pos;
  logic [7:0]  m_frm [6];
  longint      m_last;
  logic [31:0] m_sp;
  logic [7:0]  m_cm;
  logic        m_spu, m_cmu;
  logic [15:0] m_fc, m_ce, m_to;

  // CRC as polynomial long division of msg*x^8 by 0x107.
  function automatic logic [7:0] crc_ref(input logic [47:0] msg);
    logic [55:0] r;
    r = {msg, 8'h00};
    for (int i = 55; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic mdl_reset();
    m_pos = 0; m_last = cyc;
    m_sp = '0; m_cm = '0; m_spu = 1'b0; m_cmu = 1'b0;
    m_fc = '0; m_ce = '0; m_to = '0;
  endtask

  task automatic mdl_step(input logic v, input logic [7:0] d);
    m_spu = 1'b0;
    m_cmu = 1'b0;
    if (m_pos >= 2 && (cyc - m_last - 1) >= longint'(T)) begin
      m_pos = 0;
      m_to  = sat(m_to);
    end
    if (v) begin
      m_last = cyc;
      if (m_pos == 0) begin
        m_pos = (d == 8'h55) ? 1 : 0;
      end else if (m_pos == 1) begin
        m_pos = (d == 8'hAA) ? 2 : ((d == 8'h55) ? 1 : 0);
      end else if (m_pos < 8) begin
        m_frm[m_pos-2] = d;
        m_pos++;
      end else begin
        m_pos = 0;
        if (crc_ref({m_frm[0], m_frm[1], m_frm[2], m_frm[3], m_frm[4], m_frm[5]}) != d) begin
          m_ce = sat(m_ce);
        end else if (m_frm[0] == 8'h03) begin
          m_fc = sat(m_fc);
          if (m_frm[1] == 8'h01) begin
            m_sp  = {m_frm[2], m_frm[3], m_frm[4], m_frm[5]};
            m_spu = 1'b1;
          end else if (m_frm[1] == 8'h02) begin
            m_cm  = m_frm[5];
            m_cmu = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive, advance model on the same edge, compare #1 after it.
  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    cyc++;
    if (!reset) mdl_reset();
    else        mdl_step(v, d);
    #1;
    if (setpoint_update) sp_pulses++;
    check("model",
          {setpoint, control_mode, 6'd0, setpoint_update, control_mode_update,
           frame_count, crc_error_count, timeout_count},
          {m_sp, m_cm, 6'd0, m_spu, m_cmu, m_fc, m_ce, m_to});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    idle(n);
    reset = 1'b1;
    sp_pulses = 0;
  endtask

  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) tick(1'b1, b[i]);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] cmd,
                            input logic [31:0] pay, input bit good);
    logic [7:0] c;
    logic [7:0] q[$];
    c = crc_ref({id, cmd, pay});
    if (!good) c = c ^ 8'h5A;
    q = '{8'h55, 8'hAA, id, cmd, pay[31:24], pay[23:16], pay[15:8], pay[7:0], c};
    send(q);
  endtask

  typedef struct {
    logic [7:0]  id;
    logic [7:0]  cmd;
    logic [31:0] pay;
    bit          good;
    logic [31:0] sp;
    logic [7:0]  cm;
    logic [15:0] fc;
    logic [15:0] ce;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] q[$];
    logic [7:0] frame34[$];

    tbl[0] = '{8'h03, 8'h01, 32'h0000_0100, 1'b1, 32'h0000_0100, 8'h00, 16'd1, 16'd0};
    tbl[1] = '{8'h03, 8'h02, 32'hDEAD_BE05, 1'b1, 32'h0000_0100, 8'h05, 16'd2, 16'd0};
    tbl[2] = '{8'h03, 8'h01, 32'h8000_0000, 1'b0, 32'h0000_0100, 8'h05, 16'd2, 16'd1};
    tbl[3] = '{8'h04, 8'h01, 32'h1234_5678, 1'b1, 32'h0000_0100, 8'h05, 16'd2, 16'd1};
    tbl[4] = '{8'h03, 8'h07, 32'hFFFF_FFFF, 1'b1, 32'h0000_0100, 8'h05, 16'd3, 16'd1};
    tbl[5] = '{8'h04, 8'h01, 32'h0000_0001, 1'b0, 32'h0000_0100, 8'h05, 16'd3, 16'd2};
    tbl[6] = '{8'h03, 8'h01, 32'hFFFF_FF9C, 1'b1, 32'hFFFF_FF9C, 8'h05, 16'd4, 16'd2};
    tbl[7] = '{8'h03, 8'h01, 32'h55AA_55AA, 1'b1, 32'h55AA_55AA, 8'h05, 16'd5, 16'd2};
    frame34 = '{8'h55, 8'hAA, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h0C};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    mdl_reset();
    do_reset(2);
    check("reset_state",
          {setpoint, control_mode, 6'd0, setpoint_update, control_mode_update,
           frame_count, crc_error_count, timeout_count}, 96'd0);

    // Known-good frame, motor 3; motor-4 instance must ignore it.
    send(frame34);
    idle(2);
    check("req34_setpoint", 96'(setpoint), 96'd256);
    check("req34_pulses", 96'(sp_pulses), 96'd1);
    check("req34_frames", 96'(frame_count), 96'd1);
    check("req38_other_id",
          {setpoint4, control_mode4, 6'd0, setpoint_update4, control_mode_update4,
           frame_count4, crc_error_count4, timeout_count4}, 96'd0);

    // Bad CRC byte.
    do_reset(1);
    q = frame34; q[8] = 8'h0D;
    send(q);
    idle(2);
    check("req35_setpoint", 96'(setpoint), 96'd0);
    check("req35_pulses", 96'(sp_pulses), 96'd0);
    check("req35_crcerr", 96'(crc_error_count), 96'd1);

    // Repeated sync byte before 0xAA.
    do_reset(1);
    q = frame34; q.push_front(8'h55);
    send(q);
    check("req36_setpoint", 96'(setpoint), 96'd256);

    // Timeout after exactly T idle cycles; next frame's 0x55 lands on the firing cycle.
    do_reset(1);
    q = '{8'h55, 8'hAA, 8'h03, 8'h01, 8'h00};
    send(q);
    idle(T);
    send(frame34);
    check("req37_timeouts", 96'(timeout_count), 96'd1);
    check("req37_frames", 96'(frame_count), 96'd1);
    check("req37_setpoint", 96'(setpoint), 96'd256);

    // One cycle short of the timeout: frame continues.
    do_reset(1);
    send(q);
    idle(T - 1);
    q = '{8'h00, 8'h01, 8'h00, 8'h0C};
    send(q);
    check("gap_below_timeout", {timeout_count, frame_count}, {16'd0, 16'd1});

    // No timeout while hunting.
    do_reset(1);
    tick(1'b1, 8'h55);
    idle(T + 10);
    q = frame34; q.delete(0);
    send(q);
    check("hunt_no_timeout", {timeout_count, frame_count}, {16'd0, 16'd1});

    // Reset after the 6th byte, then the remainder.
    do_reset(1);
    q = frame34[0:5];
    send(q);
    do_reset(1);
    q = frame34[6:8];
    send(q);
    idle(2);
    check("req39_after_reset",
          {setpoint, control_mode, 6'd0, 1'b0, 1'b0, frame_count, crc_error_count, timeout_count},
          96'd0);
    check("req39_pulses", 96'(sp_pulses), 96'd0);

    // Frame table, back to back with zero idle.
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].id, tbl[i].cmd, tbl[i].pay, tbl[i].good);
      check($sformatf("tbl%0d", i),
            {setpoint, control_mode, frame_count, crc_error_count, 16'd0},
            {tbl[i].sp, tbl[i].cm, tbl[i].fc, tbl[i].ce, 16'd0});
    end

    // Random traffic with gaps, junk, resyncs and occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [7:0]  id, cmd, c;
      logic [31:0] pay;
      int          r;
      r = int'($urandom_range(0, 99));
      if (r < 2) do_reset(1);
      if (r >= 2 && r < 10) tick(1'b1, 8'($urandom));
      if (r >= 10 && r < 14) tick(1'b1, 8'h55);
      id  = ($urandom_range(0, 3) == 0) ? 8'h04 : 8'h03;
      r   = int'($urandom_range(0, 9));
      cmd = (r < 4) ? 8'h01 : ((r < 8) ? 8'h02 : 8'($urandom));
      pay = $urandom;
      c   = crc_ref({id, cmd, pay});
      if ($urandom_range(0, 9) == 0) c = c ^ 8'($urandom_range(1, 255));
      q = '{8'h55, 8'hAA, id, cmd, pay[31:24], pay[23:16], pay[15:8], pay[7:0], c};
      foreach (q[i]) begin
        r = int'($urandom_range(0, 199));
        if (i >= 3 && r == 0)      idle(T - 1);
        else if (i >= 3 && r == 1) idle(T);
        else if (i >= 3 && r == 2) idle(T + 3);
        else if (r < 15)           idle(int'($urandom_range(1, 3)));
        tick(1'b1, q[i]);
      end
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icebus_frame_receiver.md
ICEBUS_FRAME_RECEIVER -- requirements
Module: icebus_frame_receiver

Interface
REQ-001 Parameter MOTOR_ID, 8'h00: frame motor_id this instance accepts.
REQ-002 Parameter CLOCK_FREQ_HZ, 50_000_000: clk frequency.
REQ-003 Parameter BAUDRATE, 115200: line rate; TIMEOUT_CYCLES = 20*CLOCK_FREQ_HZ/BAUDRATE (two byte times).
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 rx_data  in  8  byte from UART receiver.
REQ-007 rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-008 setpoint  out  32  last accepted signed setpoint.
REQ-009 control_mode  out  8  last accepted control mode.
REQ-010 setpoint_update  out  1  one-cycle pulse on setpoint change.
REQ-011 control_mode_update  out  1  one-cycle pulse on control_mode change.
REQ-012 frame_count  out  16  valid frames for this MOTOR_ID, saturating.
REQ-013 crc_error_count  out  16  CRC failures, any motor_id, saturating.
REQ-014 timeout_count  out  16  mid-frame timeouts, saturating.

Function
REQ-015 Frame: 0x55, 0xAA, motor_id, cmd, P3, P2, P1, P0 (big-endian), crc.
REQ-016 CRC-8 poly 0x07, init 0x00, no reflection, no final XOR, over motor_id..P0.
REQ-017 States: HUNT0, HUNT1, ID, CMD, PAY, CRC; advance only on rx_valid.
REQ-018 HUNT0: 0x55 -> HUNT1; else stay.
REQ-019 HUNT1: 0xAA -> ID; 0x55 -> stay HUNT1; else -> HUNT0.
REQ-020 ID -> CMD; CMD -> PAY; PAY takes exactly 4 bytes (2-bit counter) -> CRC; CRC -> HUNT0.
REQ-021 Bytes 0x55/0xAA after HUNT1 are data; no mid-frame resync.
REQ-022 CRC state, crc match and motor_id==MOTOR_ID, cmd 0x01: setpoint <= payload, setpoint_update pulses cycle after CRC byte strobe.
REQ-023 Same, cmd 0x02: control_mode <= P0, control_mode_update pulses cycle after CRC byte strobe; P3..P1 ignored.
REQ-024 Valid frame, own motor_id: frame_count increments, including unknown cmd (no output change, no pulse).
REQ-025 Crc match, other motor_id: frame silently dropped, no counter change.
REQ-026 Crc mismatch: outputs unchanged, crc_error_count increments.
REQ-027 Inter-byte gap counter clears on every rx_valid; in ID..CRC, reaching TIMEOUT_CYCLES -> HUNT0, timeout_count increments, partial frame discarded.
REQ-028 rx_valid on the cycle the timeout fires: byte processed in HUNT0.
REQ-029 No timeout in HUNT0/HUNT1.
REQ-030 Counters saturate at 16'hFFFF.
REQ-031 Back-to-back frames with zero idle cycles accepted.

Reset
REQ-032 reset low at clk edge: state HUNT0, setpoint 0, control_mode 0, update pulses 0, all counters 0, gap counter 0, CRC accumulator 0.
REQ-033 Reset mid-frame discards partial frame; no pulse produced.

Verification
REQ-034 MOTOR_ID=3; bytes 55 AA 03 01 00 00 01 00 0C -> setpoint=256, setpoint_update one pulse, frame_count=1.
REQ-035 Same frame, crc byte 0x0D -> setpoint=0, no pulse, crc_error_count=1.
REQ-036 Bytes 55 55 AA 03 01 00 00 01 00 0C -> accepted, setpoint=256.
REQ-037 55 AA 03 01 00 then idle TIMEOUT_CYCLES -> timeout_count=1, state HUNT0; full valid frame next -> accepted.
REQ-038 Same valid frame with MOTOR_ID=4 -> no change, all counters 0.
REQ-039 reset low after 6th byte of frame, then released and remaining bytes sent -> no pulse, setpoint=0, counters 0.
